// File: rtl/mul_accumulator.sv
// mul_accumulator: sums 64-bit unsigned products into a wide accumulator and
// presents each group's sum, beat count and sticky wrap flag once the group's
// last beat has been taken. One beat per cycle while accumulating; the result
// is held on a valid/ready handshake and the block clears itself on exit.
module mul_accumulator #(
  parameter int unsigned ACC_W = 72,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {
    ST_ACC  = 1'b0,  // accepting product beats
    ST_HOLD = 1'b1   // group result presented, input stalled
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ovf_q,   ovf_d;

  // One bit wider than the accumulator so the carry out of the top bit is
  // visible for the sticky wrap flag.
  logic [ACC_W:0]     sum_ext;
  logic               in_fire;
  logic               out_fire;

  // Handshakes decode straight from the state flop, so neither ready nor
  // valid ever depends combinationally on the opposite side's signal.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign in_fire   = in_valid  & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Results read as zero while accumulating so partial sums never leak out.
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_count = out_valid ? cnt_q : '0;
  assign out_ovf   = out_valid & ovf_q;

  // Next-state and datapath: accumulate on accepted beats, clear on result exit.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(in_prod);

    unique case (state_q)
      ST_ACC: begin
        if (in_fire) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          // Count saturates instead of wrapping back to zero.
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (in_last) begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // No bypass: the cycle that retires the result never takes a beat.
        if (out_fire) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACC;
        end
      end

      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // State registers with synchronous reset; a reset drops any partial group
  // and any pending result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// Self-checking bench for mul_accumulator. Three instances share one input
// stream: the default 72/8 configuration, a 64-bit accumulator (wrap cases)
// and a 2-bit counter (saturation cases). A plain-arithmetic model keeps the
// exact, untruncated group total and beat count; each instance's expected
// outputs are that total modulo 2^ACC_W, wrap = total >= 2^ACC_W, and the
// count clamped to 2^CNT_W-1.
module tb_mul_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy_a, vld_a, ovf_a;
  logic [71:0] sum_a;
  logic [7:0]  cnt_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [63:0] sum_b;
  logic [7:0]  cnt_b;
  logic        rdy_c, vld_c, ovf_c;
  logic [71:0] sum_c;
  logic [1:0]  cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: exact running total of the open group and completed groups.
  logic [127:0] cur_total = '0;
  int           cur_n     = 0;
  logic [127:0] res_total[$];
  int           res_n[$];

  always #5 clk = ~clk;

  mul_accumulator #(.ACC_W(72), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .in_prod(in_prod), .in_last(in_last), .out_valid(vld_a),
    .out_ready(out_ready), .out_sum(sum_a), .out_count(cnt_a), .out_ovf(ovf_a)
  );

  mul_accumulator #(.ACC_W(64), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .in_prod(in_prod), .in_last(in_last), .out_valid(vld_b),
    .out_ready(out_ready), .out_sum(sum_b), .out_count(cnt_b), .out_ovf(ovf_b)
  );

  mul_accumulator #(.ACC_W(72), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
    .in_prod(in_prod), .in_last(in_last), .out_valid(vld_c),
    .out_ready(out_ready), .out_sum(sum_c), .out_count(cnt_c), .out_ovf(ovf_c)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mod_w(input logic [127:0] t, input int w);
    return t & ((128'(1) << w) - 128'(1));
  endfunction

  function automatic logic wrapped(input logic [127:0] t, input int w);
    return (t >> w) != 128'(0);
  endfunction

  function automatic int sat(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  // Compare all three instances' result outputs against the model.
  task automatic check_res(input string tag, input logic [127:0] t, input int n);
    check({tag, "_sum72"},  sum_a, mod_w(t, 72));
    check({tag, "_cnt8"},   cnt_a, 128'(sat(n, 8)));
    check({tag, "_ovf72"},  ovf_a, 128'(wrapped(t, 72)));
    check({tag, "_sum64"},  sum_b, mod_w(t, 64));
    check({tag, "_ovf64"},  ovf_b, 128'(wrapped(t, 64)));
    check({tag, "_cnt2"},   cnt_c, 128'(sat(n, 2)));
    check({tag, "_sum72c"}, sum_c, mod_w(t, 72));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  {rdy_a, rdy_b, rdy_c}, 128'(3'b111));
    check({tag, "_out_valid"}, {vld_a, vld_b, vld_c}, 128'(3'b000));
    check({tag, "_sum"},       sum_a | 72'(sum_b) | sum_c, 128'(0));
    check({tag, "_cnt_ovf"},   {cnt_a, cnt_b, cnt_c, ovf_a, ovf_b, ovf_c}, 128'(0));
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    cur_total = '0;
    cur_n     = 0;
    res_total.delete();
    res_n.delete();
  endtask

  // Present one beat and hold it until accepted; the model records it on accept.
  task automatic beat(input logic [63:0] p, input logic last, input bit no_stall);
    int waits;
    waits    = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    if (no_stall) check("no_stall", rdy_a, 128'(1));
    while (!rdy_a && waits < 20) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (!rdy_a) begin
      check("beat_timeout", 128'(0), 128'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cur_total += 128'(p);
    cur_n++;
    if (last) begin
      res_total.push_back(cur_total);
      res_n.push_back(cur_n);
      cur_total = '0;
      cur_n     = 0;
      in_valid  = 1'b0;
    end
  endtask

  // Called right after a last beat: result must already be up, stay stable
  // for 'delay' stalled cycles, then retire and drop back to accumulating.
  task automatic take_result(input int delay);
    logic [127:0] t;
    int           n;
    check("out_valid_rise", {vld_a, vld_b, vld_c}, 128'(3'b111));
    check("in_ready_in_hold", rdy_a, 128'(0));
    if (res_total.size() == 0) begin
      check("no_expected_result", 128'(0), 128'(1));
      return;
    end
    t = res_total.pop_front();
    n = res_n.pop_front();
    out_ready = 1'b0;
    repeat (delay) begin
      check_res("hold_stable", t, n);
      @(posedge clk);
      #1;
      check("hold_valid", vld_a, 128'(1));
      check("hold_in_ready", rdy_a, 128'(0));
    end
    out_ready = 1'b1;
    check_res("result", t, n);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("exit_out_valid", vld_a, 128'(0));
    check("exit_in_ready", rdy_a, 128'(1));
    check("exit_sum_zero", sum_a, 128'(0));
  endtask

  initial begin
    logic [31:0] a, b;
    int          len;

    // Reset state, then a one-beat group in the very first cycle after reset.
    do_reset();
    check_idle("reset");
    beat(64'h10, 1'b1, 1'b1);
    take_result(0);
    check_idle("after_single");

    // Back-to-back three-beat group with no input stall.
    beat(64'd3, 1'b0, 1'b1);
    beat(64'd5, 1'b0, 1'b1);
    beat(64'hFFFF_FFFE_0000_0001, 1'b1, 1'b1);
    check("three_beat_sum", sum_a, 128'h0000_0000_FFFF_FFFE_0000_0009);
    take_result(0);

    // Backpressure: a last beat waits during five stalled HOLD cycles and is
    // taken one cycle after the result retires.
    beat(64'd9, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_prod  = 64'h42;
    in_last  = 1'b1;
    take_result(5);
    beat(64'h42, 1'b1, 1'b1);
    take_result(1);

    // Wrap at 64 bits, then a fresh group shows the flag cleared.
    beat(64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
    beat(64'hFFFF_FFFE_0000_0001, 1'b1, 1'b1);
    check("wrap64_sum", sum_b, 128'hFFFF_FFFC_0000_0002);
    check("wrap64_ovf", ovf_b, 128'(1));
    take_result(2);
    beat(64'd1, 1'b1, 1'b1);
    check("wrap64_cleared", ovf_b, 128'(0));
    take_result(0);

    // Five beats of 1: the 2-bit count saturates at 3.
    for (int i = 0; i < 5; i++) beat(64'd1, i == 4, 1'b1);
    check("sat2_count", cnt_c, 128'(3));
    take_result(0);

    // 260 all-ones beats: 8-bit count saturates and 72 bits wrap.
    for (int i = 0; i < 260; i++) beat(64'hFFFF_FFFF_FFFF_FFFF, i == 259, 1'b0);
    check("sat8_count", cnt_a, 128'(255));
    take_result(1);

    // Reset mid-group discards the partial sum.
    beat(64'd100, 1'b0, 1'b1);
    beat(64'd200, 1'b0, 1'b1);
    do_reset();
    check_idle("reset_mid_group");
    beat(64'd7, 1'b1, 1'b1);
    check("after_rst_sum", sum_a, 128'(7));
    check("after_rst_cnt", cnt_a, 128'(1));
    take_result(0);

    // Reset while a result is held discards it.
    beat(64'd11, 1'b1, 1'b1);
    do_reset();
    check_idle("reset_in_hold");

    // Randomized groups of 32x32 products with idle gaps carrying junk and
    // random result backpressure.
    for (int g = 0; g < 100; g++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_prod  = {$urandom, $urandom};
          in_last  = 1'($urandom);
          @(posedge clk);
          #1;
        end
        a = $urandom;
        b = $urandom;
        beat(64'(a) * 64'(b), k == len - 1, 1'b0);
      end
      take_result($urandom_range(0, 3));
    end
    check_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global bound in case something stalls outside the per-beat limits.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_accumulator.md
# mul_accumulator

Downstream consumer of the 64-bit unsigned product from `multiplier`. Accepts one product per beat over a valid/ready handshake and sums products into a wide accumulator. At the end of a group, marked by `in_last`, it presents the sum, beat count and sticky overflow flag on an output valid/ready handshake, then clears itself for the next group. Used for dot-product and multiply-accumulate sequences built on the combinational multiplier.

## Interface
- `ACC_W`, 72: accumulator and `out_sum` width; must be ≥ 64.
- `CNT_W`, 8: beat-counter width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_prod`  in  64  unsigned product from `multiplier`.
- `in_last`  in  1  final beat of the current group; qualified by `in_valid`.
- `out_valid`  out  1  group result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  ACC_W  sum of the group's products, modulo 2^ACC_W.
- `out_count`  out  CNT_W  beats in the group, saturating.
- `out_ovf`  out  1  sticky: the sum wrapped past 2^ACC_W at least once in the group.

## Operation
- Two states: ACC (accepting beats) and HOLD (result presented).
- Reset: state ACC; acc = 0; count = 0; ovf = 0; `out_valid` = 0; `in_ready` = 1; `out_sum`, `out_count`, `out_ovf` = 0.
- ACC:
  - `in_ready` = 1, `out_valid` = 0.
  - On accept (`in_valid` & `in_ready`): acc ← acc + zero-extend(`in_prod`), truncated to ACC_W.
  - ovf ← ovf | carry-out of bit ACC_W-1.
  - count ← count + 1, saturating at 2^CNT_W − 1. No wrap to 0.
  - If `in_last` is set on the accepted beat, go to HOLD.
- HOLD:
  - `in_ready` = 0, `out_valid` = 1.
  - `out_sum`/`out_count`/`out_ovf` are the registered acc/count/ovf and stay stable until the handshake.
  - On `out_valid` & `out_ready`: acc, count and ovf clear to 0; return to ACC.
- `in_valid` without `in_last` only updates the running sum. No output is produced until a last beat.
- `in_prod` and `in_last` are don't-care when `in_valid` = 0 or `in_ready` = 0.
- Outputs are visible only in HOLD. In ACC they read 0, not partial sums.
- Arithmetic is unsigned throughout. No sign extension.

## Timing
- One beat per cycle sustained in ACC. No bubbles between non-last beats.
- Latency: `out_valid` rises in the cycle after the last beat is accepted (1 cycle).
- Minimum group period is 2 cycles: last-beat accept, then a HOLD cycle with `out_ready` = 1.
- HOLD-exit cycle: `in_ready` is still 0. The next beat is accepted no earlier than the following cycle. There is no same-cycle bypass of the output handshake into a new group.
- `out_ready` held low: remain in HOLD indefinitely with all outputs stable.
- `rst` mid-group or in HOLD: next cycle is in the reset state. The partial group and the pending result are discarded.
- A beat with `in_last` in the first cycle after reset is a valid one-beat group.
- `in_ready` depends only on state, never combinationally on `in_valid`.
- `out_valid` depends only on state, never combinationally on `out_ready`.

## Test plan
- Single-beat group: `in_prod` = 0x10 with `in_last`, `out_ready` = 1 → next cycle `out_valid` = 1, `out_sum` = 0x10, `out_count` = 1, `out_ovf` = 0. Back in ACC one cycle later.
- Three-beat stream, back-to-back: 3, 5, 0xFFFFFFFE00000001 (the last beat carries `in_last`) → `out_sum` = 0xFFFFFFFE00000009, `out_count` = 3, no stall on input.
- Backpressure: `out_ready` = 0 for 5 cycles while `in_valid` = 1 → `in_ready` = 0 throughout and outputs stable. Release → result accepted; the queued beat is accepted one cycle after HOLD exit.
- Overflow at `ACC_W` = 64: two beats of 0xFFFFFFFE00000001 → `out_sum` = 0xFFFFFFFC00000002, `out_ovf` = 1. The next group of value 1 gives `out_sum` = 1, `out_ovf` = 0 (flag cleared).
- Count saturation at `CNT_W` = 2: five beats of 1 → `out_count` = 3, `out_sum` = 5.
- Reset mid-group: two beats accepted, then `rst` pulsed → the next group {7 with `in_last`} yields `out_sum` = 7, `out_count` = 1.
- Randomized cross-check: 100 groups of random 32-bit a, b through `multiplier` into this block, with random `out_ready` → each result matches a reference sum of a*b computed modulo 2^ACC_W.
